// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential packed-BCD to unsigned binary converter. A BCD word is
//            captured on start, and one digit is folded per clock into an
//            accumulator, most-significant digit first (acc = acc*10 + digit).
//            The result is presented with a one-cycle done pulse.
// Ports    : clk     - clock, rising edge
//            rst_n   - asynchronous active-low reset
//            start   - conversion request (accepted in IDLE or DONE)
//            bcd_in  - packed BCD, digit DIGITS-1 in the MSBs
//            busy    - high while digits are being folded
//            done    - one-cycle pulse, bin_out/err valid
//            bin_out - binary result, held until the next completion
//            err     - invalid-digit flag, qualified by done
// Config   : define BCD2BIN_ERR_CHECK_EN to flag digits > 9. When it is
//            defined, bin_out is forced to 0 on error. When it is undefined,
//            err is tied low and digits 10-15 are used arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q,    sr_d;
  logic [BIN_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;

  logic [3:0]         digit;
  logic [BIN_W-1:0]   acc_next;

  // The digit being consumed is always the top nibble; the register shifts
  // left after each fold so the next digit rises into place.
  assign digit    = sr_q[SR_W-1 -: 4];
  // acc*10 as shift-and-add; wraps modulo 2^BIN_W by construction.
  assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

`ifdef BCD2BIN_ERR_CHECK_EN
  logic flag_q, flag_d;
  logic err_q,  err_d;
  logic digit_bad;
  logic flag_final;

  assign digit_bad  = (digit > 4'd9);
  // Include the digit consumed on the final fold, which is not yet in flag_q.
  assign flag_final = flag_q | digit_bad;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_ERR_CHECK_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d    = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BCD2BIN_ERR_CHECK_EN
          flag_d  = 1'b0;
`endif
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        acc_d = acc_next;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef BCD2BIN_ERR_CHECK_EN
        flag_d = flag_final;
`endif
        if (cnt_q == LAST_DIGIT) begin
          state_d = DONE;
`ifdef BCD2BIN_ERR_CHECK_EN
          err_d = flag_final;
          bin_d = flag_final ? '0 : acc_next;
`else
          bin_d = acc_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // All outputs come straight from flops: no input-to-output combinational path.
  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign bin_out = bin_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin_seq
// Purpose  : Self-checking bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7).
//            Expected results come from a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    bin_out;
  logic                err;

  int n_assert;
  int n_fail;

  bcd_to_bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: decimal value of the digit string, then reduced to BIN_W bits.
  function automatic void model(input logic [4*DIGITS-1:0] b,
                                output logic [BIN_W-1:0] v,
                                output logic e);
    longint s;
    int     dg;
    s = 0;
    e = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dg = int'((b >> (4 * d)) & 4'hF);
      s  = s * 10 + dg;
      if (dg > 9) e = 1'b1;
    end
`ifdef BCD2BIN_ERR_CHECK_EN
    v = e ? '0 : BIN_W'(s % (longint'(1) << BIN_W));
`else
    e = 1'b0;
    v = BIN_W'(s % (longint'(1) << BIN_W));
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [BIN_W-1:0] exp_bin, input logic exp_err);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " bin"},  32'(bin_out), 32'(exp_bin));
    check({tag, " err"},  32'(err), 32'(exp_err));
  endtask

  // Called at a falling edge. Starts one conversion, optionally toggling
  // start / bcd_in during CONV (must be ignored), and checks the full timing.
  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input bit noise);
    logic [BIN_W-1:0] ev;
    logic             ee;
    model(bcd, ev, ee);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    check("conv busy", 32'(busy), 32'd1);
    check("conv done", 32'(done), 32'd0);
    start  = noise;
    bcd_in = 8'($urandom);
    for (int i = 1; i < DIGITS; i++) begin
      @(negedge clk);
      check("conv busy", 32'(busy), 32'd1);
      check("conv done", 32'(done), 32'd0);
      start  = noise;
      bcd_in = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("done pulse", 32'(done), 32'd1);
    check("done busy",  32'(busy), 32'd0);
    check("result bin", 32'(bin_out), 32'(ev));
    check("result err", 32'(err), 32'(ee));
    @(negedge clk);
    check_idle("after done", ev, ee);
  endtask

  initial begin
    logic [BIN_W-1:0] ev;
    logic             ee;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bcd_in   = '0;

    // Reset and idle.
    repeat (2) @(negedge clk);
    check_idle("reset", '0, 1'b0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("idle", '0, 1'b0);
    end

    // Basic conversion.
    run_conv(8'h42, 1'b0);

    // Counting sweep 00..99, each from IDLE.
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        run_conv({4'(t), 4'(o)}, 1'b0);
      end
    end

    // Start pulses during CONV must not disturb the result.
    run_conv(8'h64, 1'b1);
    run_conv(8'h31, 1'b1);

    // Back-to-back: start held high, next word accepted in DONE.
    start  = 1'b1;
    bcd_in = 8'h17;
    @(negedge clk);
    check("b2b busy1", 32'(busy), 32'd1);
    bcd_in = 8'h58;
    @(negedge clk);
    check("b2b busy1b", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b done1", 32'(done), 32'd1);
    check("b2b bin1",  32'(bin_out), 32'd17);
    @(negedge clk);
    check("b2b nogap busy", 32'(busy), 32'd1);
    check("b2b nogap done", 32'(done), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("b2b busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b done2", 32'(done), 32'd1);
    check("b2b bin2",  32'(bin_out), 32'd58);
    @(negedge clk);
    check_idle("b2b end", 7'd58, 1'b0);

    // Asynchronous reset mid-conversion.
    start  = 1'b1;
    bcd_in = 8'h73;
    @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async rst", '0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_idle("in rst", '0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no done after rst", 32'(done), 32'd0);
    end
    run_conv(8'h05, 1'b0);

    // Invalid digit.
    run_conv(8'hA3, 1'b0);
    model(8'hA3, ev, ee);
`ifdef BCD2BIN_ERR_CHECK_EN
    check("A3 model err", 32'(ee), 32'd1);
`else
    check("A3 bin 103", 32'(bin_out), 32'd103);
`endif

    // Randomized words, including invalid digits.
    for (int k = 0; k < 60; k++) begin
      run_conv(8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
